// File: rtl/addsub_flag_buffer_if.sv
// rtl/addsub_flag_buffer_if.sv - result handshake bundle between adder/subtractor and flag buffer
interface addsub_flag_buffer_if #(
   parameter int n = 4
);
   logic         in_valid;
   logic         in_ready;
   logic [n-1:0] in_s;
   logic         in_c_out;
   logic         in_x_msb;
   logic         in_y_msb;
   logic         in_add_n;
   logic         out_valid;
   logic         out_ready;
   logic [n-1:0] out_s;
   logic         out_z;
   logic         out_n;
   logic         out_c;
   logic         out_v;

   modport master (
      output in_valid, in_s, in_c_out, in_x_msb, in_y_msb, in_add_n, out_ready,
      input  in_ready, out_valid, out_s, out_z, out_n, out_c, out_v
   );

   modport slave (
      input  in_valid, in_s, in_c_out, in_x_msb, in_y_msb, in_add_n, out_ready,
      output in_ready, out_valid, out_s, out_z, out_n, out_c, out_v
   );
endinterface

// File: rtl/addsub_flag_buffer.sv
// rtl/addsub_flag_buffer.sv - Z/N/C/V flag derivation with 2-entry result FIFO and op counter
module addsub_flag_buffer #(
   parameter int n  = 4,
   parameter int CW = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   addsub_flag_buffer_if.slave  bus,
   output logic [CW-1:0]        op_count
);
   typedef struct packed {
      logic [n-1:0] s;
      logic         z;
      logic         nf;
      logic         c;
      logic         v;
   } entry_t;

   entry_t       mem_q [2];
   entry_t       wr_entry;
   entry_t       head;
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   occ_q, occ_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic         push, pop;

   // in_ready looks only at registered occupancy, so a pop never frees a slot in the same cycle
   assign bus.in_ready  = (occ_q != 2'd2) & ~rst;
   assign bus.out_valid = (occ_q != 2'd0);
   assign push = bus.in_valid & bus.in_ready;
   assign pop  = bus.out_valid & bus.out_ready;

   always_comb begin
      wr_entry    = '0;
      wr_entry.s  = bus.in_s;
      wr_entry.z  = (bus.in_s == '0);
      wr_entry.nf = bus.in_s[n-1];
      wr_entry.c  = bus.in_c_out ^ bus.in_add_n;
      wr_entry.v  = (bus.in_x_msb == (bus.in_y_msb ^ bus.in_add_n)) &
                    (bus.in_s[n-1] != bus.in_x_msb);
   end

   always_comb begin
      occ_d    = occ_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         wr_ptr_d = ~wr_ptr_q;
         cnt_d    = cnt_q + CW'(1);
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      if (push && !pop) begin
         occ_d = occ_q + 2'd1;
      end else if (pop && !push) begin
         occ_d = occ_q - 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
         cnt_q    <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         cnt_q    <= cnt_d;
      end
   end

   assign head      = mem_q[rd_ptr_q];
   assign bus.out_s = head.s;
   assign bus.out_z = head.z;
   assign bus.out_n = head.nf;
   assign bus.out_c = head.c;
   assign bus.out_v = head.v;
   assign op_count  = cnt_q;
endmodule

// File: tb/tb_addsub_flag_buffer.sv
// tb/tb_addsub_flag_buffer.sv - scoreboard bench for addsub_flag_buffer
module tb_addsub_flag_buffer;
   localparam int N  = 4;
   localparam int CW = 8;

   typedef struct packed {
      logic [N-1:0] s;
      logic         z;
      logic         nf;
      logic         c;
      logic         v;
   } exp_t;

   logic          clk;
   logic          rst;
   logic [CW-1:0] op_count;

   addsub_flag_buffer_if #(.n(N)) bus ();

   addsub_flag_buffer #(.n(N), .CW(CW)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .op_count (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int pushes = 0;
   int pops   = 0;
   logic [CW-1:0] model_cnt = '0;
   exp_t sb_q [$];
   logic [N-1:0] cur_x, cur_y;
   logic         cur_sub;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Flags from the arithmetic meaning of the operation, independent of the adder bit tricks
   function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y, input logic sub);
      exp_t e;
      int xs, ys, r;
      xs   = $signed(x);
      ys   = $signed(y);
      r    = sub ? xs - ys : xs + ys;
      e.s  = sub ? x - y : x + y;
      e.z  = (e.s == '0);
      e.nf = e.s[N-1];
      e.c  = sub ? (int'(x) < int'(y)) : ((int'(x) + int'(y)) > 15);
      e.v  = (r > 7) || (r < -8);
      return e;
   endfunction

   task automatic set_in(input logic [N-1:0] x, input logic [N-1:0] y, input logic sub);
      logic [N:0] full;
      full          = {1'b0, x} + {1'b0, (sub ? ~y : y)} + {{N{1'b0}}, sub};
      cur_x         = x;
      cur_y         = y;
      cur_sub       = sub;
      bus.in_s      = full[N-1:0];
      bus.in_c_out  = full[N];
      bus.in_x_msb  = x[N-1];
      bus.in_y_msb  = y[N-1];
      bus.in_add_n  = sub;
      bus.in_valid  = 1'b1;
   endtask

   task automatic send(input logic [N-1:0] x, input logic [N-1:0] y, input logic sub);
      bit ok;
      ok = 1'b0;
      set_in(x, y, sub);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Monitor: compare head on every pop, queue expected on every push, track the counter
   always @(negedge clk) begin
      if (!rst) begin
         chk("op_count", 32'(op_count), 32'(model_cnt));
         if (bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
               chk("sb_underflow", 1, 0);
            end else begin
               chk("sb_entry", 32'({bus.out_s, bus.out_z, bus.out_n, bus.out_c, bus.out_v}),
                   32'(sb_q[0]));
               void'(sb_q.pop_front());
            end
            pops++;
         end
         if (bus.in_valid && bus.in_ready) begin
            sb_q.push_back(model(cur_x, cur_y, cur_sub));
            model_cnt <= model_cnt + CW'(1);
            pushes++;
         end
      end
   end

   int p0, q0;

   initial begin
      rst = 1'b1;
      bus.out_ready = 1'b0;
      set_in('0, '0, 1'b0);
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 0);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_s", 32'(bus.out_s), 0);
      chk("rst_op_count", 32'(op_count), 0);
      rst = 1'b0;
      #1;
      chk("rel_in_ready", 32'(bus.in_ready), 1);

      // Latency: visible the cycle after the push edge
      bus.out_ready = 1'b1;
      send(4'd7, 4'd1, 1'b0);
      chk("lat_valid", 32'(bus.out_valid), 1);
      chk("lat_flags", 32'({bus.out_s, bus.out_z, bus.out_n, bus.out_c, bus.out_v}),
          32'({4'b1000, 1'b0, 1'b1, 1'b0, 1'b1}));
      chk("lat_count", 32'(op_count), 1);

      send(4'd3, 4'd3, 1'b1);
      chk("zero_flags", 32'({bus.out_s, bus.out_z, bus.out_n, bus.out_c, bus.out_v}),
          32'({4'b0000, 1'b1, 1'b0, 1'b0, 1'b0}));
      send(4'd0, 4'd1, 1'b1);
      chk("borrow_flags", 32'({bus.out_s, bus.out_z, bus.out_n, bus.out_c, bus.out_v}),
          32'({4'b1111, 1'b0, 1'b1, 1'b1, 1'b0}));
      send(4'd8, 4'd1, 1'b1);
      chk("subov_flags", 32'({bus.out_s, bus.out_z, bus.out_n, bus.out_c, bus.out_v}),
          32'({4'b0111, 1'b0, 1'b0, 1'b0, 1'b1}));
      repeat (2) @(posedge clk);
      #1;
      chk("drained", 32'(bus.out_valid), 0);

      // Backpressure: third result must wait upstream
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      set_in(4'd5, 4'd6, 1'b0);
      @(posedge clk); #1;
      chk("bp_ready1", 32'(bus.in_ready), 1);
      set_in(4'd9, 4'd2, 1'b1);
      @(posedge clk); #1;
      chk("bp_ready_full", 32'(bus.in_ready), 0);
      set_in(4'd12, 4'd4, 1'b0);
      @(posedge clk); #1;
      chk("bp_hold_ready", 32'(bus.in_ready), 0);
      chk("bp_hold_valid", 32'(bus.out_valid), 1);
      chk("bp_hold_head", 32'(bus.out_s), 32'(4'd11));
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_full_pop_ready", 32'(bus.in_ready), 0);
      @(posedge clk); #1;
      chk("bp_after_pop_ready", 32'(bus.in_ready), 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("bp_drained", 32'(sb_q.size()), 0);

      // Streaming: one result per cycle, counter wraps past 255
      p0 = pushes;
      q0 = pops;
      for (int i = 0; i < 300; i++) begin
         set_in(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         @(posedge clk); #1;
      end
      chk("stream_pushes", 32'(pushes - p0), 300);
      chk("stream_pops", 32'(pops - q0), 299);
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("stream_drained", 32'(sb_q.size()), 0);

      // Asynchronous reset with two entries held
      bus.out_ready = 1'b0;
      send(4'd2, 4'd3, 1'b0);
      send(4'd6, 4'd6, 1'b1);
      chk("pre_rst_full", 32'(bus.in_ready), 0);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_valid", 32'(bus.out_valid), 0);
      chk("arst_out", 32'({bus.out_s, bus.out_z, bus.out_n, bus.out_c, bus.out_v}), 0);
      chk("arst_count", 32'(op_count), 0);
      chk("arst_ready", 32'(bus.in_ready), 0);
      sb_q.delete();
      model_cnt = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("post_rst_ready", 32'(bus.in_ready), 1);
      chk("post_rst_valid", 32'(bus.out_valid), 0);
      bus.out_ready = 1'b1;
      send(4'd1, 4'd1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("final_empty", 32'(sb_q.size()), 0);
      chk("final_valid", 32'(bus.out_valid), 0);
      chk("final_count", 32'(op_count), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
